// File: rtl/mul_seq_if.sv
// +--------------------------------------------------------------------+
// | mul_seq_if : start/busy/done handshake bundle for mul_seq           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface mul_seq_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [1:0]           state;

   modport master (
      output start, a, b,
      input  busy, done, product, state
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, state
   );
endinterface

`default_nettype wire

// File: rtl/mul_seq.sv
// +--------------------------------------------------------------------+
// | mul_seq : iterative shift-add WIDTHxWIDTH multiplier (MULT unit)    |
// | Optional two's-complement operands via MUL_SEQ_SIGNED_EN. Rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   mul_seq_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH:0]       acc;
   logic [WIDTH:0]       sum;
   logic [CNT_W-1:0]     count;
   logic [2*WIDTH-1:0]   product_q;
   logic [2*WIDTH-1:0]   prod_raw;
   logic [2*WIDTH-1:0]   prod_final;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;

   assign sum      = acc + {1'b0, (mplier[0] ? a_reg : {WIDTH{1'b0}})};
   // Value {acc[WIDTH-1:0], mplier} will hold after the final shift step
   assign prod_raw = {sum, mplier[WIDTH-1:1]};

`ifdef MUL_SEQ_SIGNED_EN
   logic neg;

   assign a_in       = bus.a[WIDTH-1] ? ((~bus.a) + WIDTH'(1)) : bus.a;
   assign b_in       = bus.b[WIDTH-1] ? ((~bus.b) + WIDTH'(1)) : bus.b;
   assign prod_final = neg ? ((~prod_raw) + (2*WIDTH)'(1)) : prod_raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg <= 1'b0;
      end else if (state_q == IDLE && bus.start) begin
         neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end
`else
   assign a_in       = bus.a;
   assign b_in       = bus.b;
   assign prod_final = prod_raw;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc       <= '0;
         mplier    <= '0;
         count     <= '0;
         product_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
               end
            end
            LOAD: begin
               acc    <= '0;
               mplier <= b_reg;
               count  <= CNT_W'(WIDTH);
            end
            SHIFT: begin
               acc    <= {1'b0, sum[WIDTH:1]};
               mplier <= {sum[0], mplier[WIDTH-1:1]};
               count  <= count - CNT_W'(1);
               // Registered on entry so the product is valid throughout DONE
               if (count == CNT_W'(1)) begin
                  product_q <= prod_final;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (count == CNT_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;
   assign bus.state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// +--------------------------------------------------------------------+
// | tb_mul_seq : scoreboard bench for mul_seq (latency, product, abort) |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mul_seq;

   localparam int WIDTH = 16;
   localparam int LAT   = WIDTH + 1;

   typedef struct {
      logic [2*WIDTH-1:0] prod;
      int                 t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   mul_seq_if #(.WIDTH(WIDTH)) bus ();

   mul_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MUL_SEQ_SIGNED_EN
      logic signed [2*WIDTH-1:0] sx;
      logic signed [2*WIDTH-1:0] sy;
      sx = {{WIDTH{x[WIDTH-1]}}, x};
      sy = {{WIDTH{y[WIDTH-1]}}, y};
      return sx * sy;
`else
      logic [2*WIDTH-1:0] ux;
      logic [2*WIDTH-1:0] uy;
      ux = {{WIDTH{1'b0}}, x};
      uy = {{WIDTH{1'b0}}, y};
      return ux * uy;
`endif
   endfunction

   // Scoreboard consumer: every done must match the oldest accepted request
   always @(negedge clk) begin
      if (rst && bus.done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("product", 64'(bus.product), 64'(e.prod));
            check("latency", 64'(cyc - e.t0), 64'(LAT));
         end
         done_cnt++;
      end
   end

   task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output int t0);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      t0     = cyc;
      e.prod = model(x, y);
      e.t0   = cyc;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int target;
      int n;
      target = done_cnt + 1;
      n      = 0;
      while (done_cnt < target && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (done_cnt < target) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input string tag);
      int t;
      launch(x, y, t);
      wait_done(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t_a;
      int t_b;
      int dc;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",    64'(bus.busy),    64'd0);
      check("rst_done",    64'(bus.done),    64'd0);
      check("rst_product", 64'(bus.product), 64'd0);
      check("rst_state",   64'(bus.state),   64'd0);
      rst = 1'b1;

      // Basic op with handshake timing around it
      launch(16'd3, 16'd5, t_a);
      check("load_busy",  64'(bus.busy),  64'd1);
      check("load_state", 64'(bus.state), 64'd1);
      wait_done("op_3x5");
      check("done_prod_3x5", 64'(bus.product), 64'h0000_000F);
      @(negedge clk);
      check("idle_state", 64'(bus.state), 64'd0);
      check("idle_busy",  64'(bus.busy),  64'd0);
      check("done_pulse", 64'(bus.done),  64'd0);
      repeat (3) @(negedge clk);
      check("prod_held",  64'(bus.product), 64'h0000_000F);

`ifndef MUL_SEQ_SIGNED_EN
      run_op(16'hFFFF, 16'hFFFF, "op_ffff");
      check("prod_ffff", 64'(bus.product), 64'hFFFE_0001);
`endif

      // Zero operand followed by back-to-back op at the first IDLE cycle
      launch(16'd0, 16'h1234, t_a);
      wait_done("op_zero");
      launch(16'd7, 16'd9, t_b);
      check("b2b_gap", 64'(t_b - t_a), 64'(WIDTH + 3));
      wait_done("op_7x9");

      // Start while busy must be dropped
      launch(16'd2, 16'd2, t_a);
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 16'd9;
      bus.b     = 16'd9;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("op_2x2");
      dc = done_cnt;
      repeat (25) @(negedge clk);
      check("ignored_start", 64'(done_cnt), 64'(dc));

      // Asynchronous abort mid-operation
      launch(16'd100, 16'd100, t_a);
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_product", 64'(bus.product), 64'd0);
      check("abort_busy",    64'(bus.busy),    64'd0);
      check("abort_done",    64'(bus.done),    64'd0);
      check("abort_state",   64'(bus.state),   64'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      dc = done_cnt;
      repeat (25) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'(dc));
      run_op(16'd6, 16'd7, "op_6x7");

      // Sign-boundary operands and random patterns
      run_op(16'hFFFD, 16'd5,    "op_m3x5");
      run_op(16'h8000, 16'h8000, "op_minxmin");
      run_op(16'h8000, 16'd1,    "op_minx1");
`ifdef MUL_SEQ_SIGNED_EN
      check("prod_minx1", 64'(bus.product), 64'hFFFF_8000);
`endif
      for (int i = 0; i < 4; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), "op_rand");
      end

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
